// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall controller: load-use interlock, branch flush, data-memory
// freeze with timeout into a sticky error state, plus saturating performance counters.
module pipeline_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             ex_mem_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_bubble,
    output logic             mem_error,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2,
        ST_ILLEGAL  = 2'd3
    } state_t;

    state_t           state_reg;
    logic [7:0]       wait_cnt_reg;
    logic             mem_error_reg;
    logic [CNT_W-1:0] stall_cycles_reg;
    logic [CNT_W-1:0] flush_count_reg;

    logic freeze;
    logic hazard;
    logic active;
    logic do_branch;
    logic stall_inc;

    assign freeze = mem_req && !mem_ready;
    assign hazard = ex_mem_read && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    // Only RUN and MEM_WAIT let the pipeline advance; everything else holds it.
    assign active    = !reset && ((state_reg == ST_RUN) || (state_reg == ST_MEM_WAIT));
    assign do_branch = active && !freeze && branch_taken;
    assign stall_inc = active && !pc_write;

    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        id_ex_write   = 1'b1;
        ex_mem_write  = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        mem_wb_bubble = 1'b0;
        if (!active || freeze) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_write  = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (hazard) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= ST_RUN;
            wait_cnt_reg     <= 8'd0;
            mem_error_reg    <= 1'b0;
            stall_cycles_reg <= '0;
            flush_count_reg  <= '0;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (freeze) begin
                        state_reg    <= ST_MEM_WAIT;
                        wait_cnt_reg <= 8'd1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (freeze) begin
                        // Comparing with >= keeps wait_cnt from ever wrapping.
                        if (wait_cnt_reg >= 8'(MEM_TIMEOUT)) begin
                            state_reg     <= ST_ERROR;
                            mem_error_reg <= 1'b1;
                        end else begin
                            wait_cnt_reg <= wait_cnt_reg + 8'd1;
                        end
                    end else begin
                        state_reg    <= ST_RUN;
                        wait_cnt_reg <= 8'd0;
                    end
                end
                ST_ERROR: begin
                    state_reg <= ST_ERROR;
                end
                default: begin
                    state_reg    <= ST_RUN;
                    wait_cnt_reg <= 8'd0;
                end
            endcase

            if (stall_inc && (stall_cycles_reg != '1))
                stall_cycles_reg <= stall_cycles_reg + 1'b1;
            if (do_branch && (flush_count_reg != '1))
                flush_count_reg <= flush_count_reg + 1'b1;
        end
    end

    assign mem_error    = mem_error_reg;
    assign state        = state_reg;
    assign stall_cycles = stall_cycles_reg;
    assign flush_count  = flush_count_reg;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios followed by random traffic,
// all compared against a rule-level reference model.
module tb_pipeline_ctrl;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 5;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       id_rs, id_rt, ex_rt;
    logic             id_uses_rt, ex_mem_read, branch_taken, mem_req, mem_ready;
    logic             pc_write, if_id_write, id_ex_write, ex_mem_write;
    logic             if_id_flush, id_ex_flush, mem_wb_bubble, mem_error;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    int tests = 0;
    int fails = 0;

    // Reference model: 0 = running, 1 = waiting on memory, 2 = error.
    int m_mode  = 0;
    int m_wait  = 0;
    int m_stall = 0;
    int m_flush = 0;

    pipeline_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
        .ex_mem_write(ex_mem_write), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .mem_wb_bubble(mem_wb_bubble), .mem_error(mem_error), .state(state),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    // Expected {pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush, id_ex_flush, mem_wb_bubble}
    function automatic logic [6:0] exp_ctrl();
        logic h;
        if (reset || m_mode == 2) return 7'b0000_001;
        if (mem_req && !mem_ready) return 7'b0000_001;
        if (branch_taken) return 7'b1111_110;
        h = ex_mem_read && ex_rt != 0 &&
            (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
        if (h) return 7'b0011_010;
        return 7'b1111_000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        reset = 1'b0; id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
        id_uses_rt = 1'b0; ex_mem_read = 1'b0; branch_taken = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    // Called just after a falling edge with inputs applied: check, cross the rising edge, advance model.
    task automatic tick();
        logic [6:0] e;
        logic       f;
        #1;
        e = exp_ctrl();
        f = mem_req && !mem_ready;
        chk("ctrl", 32'({pc_write, if_id_write, id_ex_write, ex_mem_write,
                         if_id_flush, id_ex_flush, mem_wb_bubble}), 32'(e));
        chk("state", 32'(state), 32'(m_mode));
        chk("mem_error", 32'(mem_error), 32'(m_mode == 2));
        chk("stall_cycles", 32'(stall_cycles), 32'(m_stall));
        chk("flush_count", 32'(flush_count), 32'(m_flush));
        $display("[TB] t=%0t rst=%0b mreq=%0b mrdy=%0b br=%0b ctrl=%b st=%0d stall=%0d flush=%0d",
                 $time, reset, mem_req, mem_ready, branch_taken, e, m_mode, m_stall, m_flush);
        @(posedge clk);
        if (reset) begin
            m_mode = 0; m_wait = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (m_mode != 2 && !e[6] && m_stall < CNT_MAX) m_stall++;
            if (e == 7'b1111_110 && m_flush < CNT_MAX) m_flush++;
            if (m_mode == 0 && f) begin
                m_mode = 1; m_wait = 1;
            end else if (m_mode == 1) begin
                if (!f) begin
                    m_mode = 0; m_wait = 0;
                end else if (m_wait == MEM_TIMEOUT) begin
                    m_mode = 2;
                end else begin
                    m_wait++;
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        clr();
        @(negedge clk);

        reset = 1'b1; tick(); tick();
        clr(); tick();
        chk("post_reset_state", 32'(state), 32'd0);

        // Load-use hazard on rs
        ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; tick();
        clr(); tick();
        chk("hazard_stall_cnt", 32'(stall_cycles), 32'd1);

        // r0 destination and unused rt never interlock
        ex_mem_read = 1'b1; tick();
        id_rs = 5'd3; id_rt = 5'd7; ex_rt = 5'd7; id_uses_rt = 1'b0; tick();
        id_uses_rt = 1'b1; tick();
        clr(); tick();

        // Branch overrides hazard
        ex_mem_read = 1'b1; ex_rt = 5'd9; id_rs = 5'd9; branch_taken = 1'b1; tick();
        clr(); tick();
        chk("branch_flush_cnt", 32'(flush_count), 32'd1);
        chk("branch_stall_cnt", 32'(stall_cycles), 32'd2);

        // Three-cycle memory freeze then completion
        mem_req = 1'b1; mem_ready = 1'b0; tick(); tick(); tick();
        mem_ready = 1'b1; tick();
        clr(); tick();
        chk("freeze_stall_cnt", 32'(stall_cycles), 32'd5);
        chk("freeze_no_error", 32'(mem_error), 32'd0);

        // Timeout into sticky error, then reset recovers
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        mem_ready = 1'b1; tick(); tick();
        chk("error_sticky", 32'(state), 32'd2);
        reset = 1'b1; tick();
        clr(); tick();
        chk("error_reset_state", 32'(state), 32'd0);
        chk("error_reset_stall", 32'(stall_cycles), 32'd0);

        // Reset taking effect mid-wait
        mem_req = 1'b1; tick(); tick();
        reset = 1'b1; tick();
        clr(); tick();

        // Freeze beats branch, then saturate stall counter with hazards
        mem_req = 1'b1; branch_taken = 1'b1; tick();
        clr(); tick();
        chk("freeze_beats_branch", 32'(flush_count), 32'd0);
        ex_mem_read = 1'b1; ex_rt = 5'd2; id_rt = 5'd2; id_uses_rt = 1'b1;
        for (int i = 0; i < CNT_MAX + 4; i++) tick();
        clr(); tick();
        chk("stall_saturated", 32'(stall_cycles), 32'(CNT_MAX));

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            reset        = ($urandom_range(0, 63) == 0);
            ex_mem_read  = 1'($urandom_range(0, 1));
            ex_rt        = 5'($urandom_range(0, 3));
            id_rs        = 5'($urandom_range(0, 3));
            id_rt        = 5'($urandom_range(0, 3));
            id_uses_rt   = 1'($urandom_range(0, 1));
            branch_taken = ($urandom_range(0, 5) == 0);
            mem_req      = 1'($urandom_range(0, 1));
            mem_ready    = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
